// File: rtl/flash_bus_arbiter_if.sv
// rtl/flash_bus_arbiter_if.sv - request/response and flash-engine bus bundle for flash_bus_arbiter
//
// Ports (as seen from the arbiter, modport slave):
//   req0/req1     in   word-read requests (0 = instruction fetch, 1 = data load)
//   addr0/addr1   in   byte address per requester, sampled at grant
//   ack0/ack1     out  one-cycle completion pulse per requester
//   rdata/err     out  read word and timeout flag, valid in the ack cycle
//   busy          out  arbiter not idle
//   fl_read_op    out  one-cycle start pulse to the flash read engine
//   fl_addr       out  word-aligned address to the flash read engine
//   fl_rdata      in   word returned by the flash read engine
//   fl_valid      in   one-cycle pulse qualifying fl_rdata
interface flash_bus_arbiter_if #(
  parameter int ADDR_W = 23
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              ack0;
  logic              ack1;
  logic [31:0]       rdata;
  logic              err;
  logic              busy;
  logic              fl_read_op;
  logic [ADDR_W-1:0] fl_addr;
  logic [31:0]       fl_rdata;
  logic              fl_valid;

  modport slave (
    input  req0, req1, addr0, addr1, fl_rdata, fl_valid,
    output ack0, ack1, rdata, err, busy, fl_read_op, fl_addr
  );

  modport master (
    output req0, req1, addr0, addr1, fl_rdata, fl_valid,
    input  ack0, ack1, rdata, err, busy, fl_read_op, fl_addr
  );
endinterface

// File: rtl/flash_bus_arbiter.sv
// rtl/flash_bus_arbiter.sv - two-port round-robin arbiter in front of a flash word-read engine
//
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  flash_bus_arbiter_if.slave (requests, acks, read data, flash-engine handshake)
//
// Parameters:
//   ADDR_W   flash byte-address width
//   TIMEOUT  cycles allowed in WAIT before an error completion (2..255)
module flash_bus_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  flash_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0]        LAST_CNT   = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state;
  logic              last_grant;
  logic              grant_idx;
  logic [7:0]        wait_cnt;

  logic              next_winner;
  logic [ADDR_W-1:0] grant_addr;

  // Round robin: with both ports requesting, the port not granted last wins.
  always_comb begin
    next_winner = 1'b0;
    if (bus.req0 && bus.req1) begin
      next_winner = ~last_grant;
    end else begin
      next_winner = bus.req1;
    end
    grant_addr = next_winner ? bus.addr1 : bus.addr0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      grant_idx      <= 1'b0;
      wait_cnt       <= 8'd0;
      bus.ack0       <= 1'b0;
      bus.ack1       <= 1'b0;
      bus.rdata      <= 32'd0;
      bus.err        <= 1'b0;
      bus.busy       <= 1'b0;
      bus.fl_read_op <= 1'b0;
      bus.fl_addr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          if (bus.req0 || bus.req1) begin
            grant_idx      <= next_winner;
            last_grant     <= next_winner;
            // Address is latched once here and held until the next grant.
            bus.fl_addr    <= grant_addr & ALIGN_MASK;
            bus.fl_read_op <= 1'b1;
            bus.busy       <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          bus.fl_read_op <= 1'b0;
          wait_cnt       <= 8'd0;
          state          <= WAIT;
        end

        WAIT: begin
          // fl_valid is checked first so it wins a same-cycle timeout.
          if (bus.fl_valid) begin
            bus.rdata <= bus.fl_rdata;
            bus.err   <= 1'b0;
            bus.ack0  <= ~grant_idx;
            bus.ack1  <= grant_idx;
            state     <= RESP;
          end else if (wait_cnt == LAST_CNT) begin
            bus.rdata <= 32'd0;
            bus.err   <= 1'b1;
            bus.ack0  <= ~grant_idx;
            bus.ack1  <= grant_idx;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          // Requests are not looked at here; the next grant comes from IDLE.
          bus.ack0  <= 1'b0;
          bus.ack1  <= 1'b0;
          bus.rdata <= 32'd0;
          bus.err   <= 1'b0;
          bus.busy  <= 1'b0;
          wait_cnt  <= 8'd0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// tb/tb_flash_bus_arbiter.sv - self-checking scoreboard bench for flash_bus_arbiter
module tb_flash_bus_arbiter;

  localparam int ADDR_W  = 23;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  flash_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  flash_bus_arbiter #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Completion monitor: every ack pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && (bus.ack0 === 1'b1 || bus.ack1 === 1'b1)) begin
      check("ack_exclusive", {63'd0, bus.ack0 & bus.ack1}, 64'd0);
      check("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ack_port", {63'd0, bus.ack1}, {63'd0, e.port});
        check("rdata", {32'd0, bus.rdata}, {32'd0, e.rdata});
        check("err", {63'd0, bus.err}, {63'd0, e.err});
      end
    end
  end

  // Flash-engine responder for one transaction. delay = WAIT cycle index in
  // which fl_valid is returned; negative means never.
  task automatic serve(input string tag, input logic [ADDR_W-1:0] exp_addr,
                       input logic [31:0] data, input int delay, input bit drop_req);
    bit found;
    bit acked;
    int cyc;
    int exp_lat;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.fl_read_op === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_issue_seen"}, {63'd0, found}, 64'd1);
    if (!found) return;
    check({tag, "_fl_addr"}, 64'(bus.fl_addr), 64'(exp_addr));
    check({tag, "_busy"}, {63'd0, bus.busy}, 64'd1);
    if (drop_req) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    acked = 1'b0;
    cyc   = 0;
    for (int c = 1; c <= TIMEOUT + 4; c++) begin
      @(negedge clk);
      cyc = c;
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        acked = 1'b1;
        break;
      end
      if (c == 1) check({tag, "_read_op_one_pulse"}, {63'd0, bus.fl_read_op}, 64'd0);
      bus.fl_valid = (delay == c - 1);
      bus.fl_rdata = (delay == c - 1) ? data : 32'h5A5A_5A5A;
    end
    bus.fl_valid = 1'b0;
    bus.fl_rdata = 32'd0;
    check({tag, "_acked"}, {63'd0, acked}, 64'd1);
    // Latency counted from the edge that sampled the request in IDLE.
    exp_lat = (delay >= 0 && delay < TIMEOUT) ? delay + 3 : TIMEOUT + 2;
    check({tag, "_latency"}, 64'(cyc + 1), 64'(exp_lat));
    check({tag, "_fl_addr_hold"}, 64'(bus.fl_addr), 64'(exp_addr));
  endtask

  initial begin
    bit found;
    rst          = 1'b1;
    bus.req0     = 1'b0;
    bus.req1     = 1'b0;
    bus.addr0    = '0;
    bus.addr1    = '0;
    bus.fl_rdata = 32'd0;
    bus.fl_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ack0", {63'd0, bus.ack0}, 64'd0);
    check("rst_ack1", {63'd0, bus.ack1}, 64'd0);
    check("rst_read_op", {63'd0, bus.fl_read_op}, 64'd0);
    check("rst_err", {63'd0, bus.err}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_rdata", {32'd0, bus.rdata}, 64'd0);
    check("rst_fl_addr", 64'(bus.fl_addr), 64'd0);
    rst = 1'b0;

    // Contention straight after reset: grants 0,1,0,1.
    bus.addr0 = 23'h000200;
    bus.addr1 = 23'h00030A;
    push_exp(1'b0, 32'h1111_0000, 1'b0);
    push_exp(1'b1, 32'h2222_0001, 1'b0);
    push_exp(1'b0, 32'h3333_0002, 1'b0);
    push_exp(1'b1, 32'h4444_0003, 1'b0);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    serve("cont0", 23'h000200, 32'h1111_0000, 0, 1'b0);
    serve("cont1", 23'h000308, 32'h2222_0001, 2, 1'b0);
    serve("cont2", 23'h000200, 32'h3333_0002, 0, 1'b0);
    serve("cont3", 23'h000308, 32'h4444_0003, 1, 1'b0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Single read, data in the second WAIT cycle.
    @(negedge clk);
    bus.addr0 = 23'h000104;
    push_exp(1'b0, 32'hDEAD_BEEF, 1'b0);
    bus.req0 = 1'b1;
    serve("single", 23'h000104, 32'hDEAD_BEEF, 1, 1'b0);
    bus.req0 = 1'b0;

    // Timeout on port 1.
    @(negedge clk);
    bus.addr1 = 23'h00ABC0;
    push_exp(1'b1, 32'd0, 1'b1);
    bus.req1 = 1'b1;
    serve("timeout", 23'h00ABC0, 32'hBAD0_BAD0, -1, 1'b0);
    bus.req1 = 1'b0;

    // Unaligned address plus fl_valid on the last WAIT cycle.
    @(negedge clk);
    bus.addr0 = 23'h000107;
    push_exp(1'b0, 32'hCAFE_F00D, 1'b0);
    bus.req0 = 1'b1;
    serve("race", 23'h000104, 32'hCAFE_F00D, TIMEOUT - 1, 1'b0);
    bus.req0 = 1'b0;

    // Request dropped after grant still completes.
    @(negedge clk);
    bus.addr1 = 23'h000042;
    push_exp(1'b1, 32'h1234_5678, 1'b0);
    bus.req1 = 1'b1;
    serve("drop", 23'h000040, 32'h1234_5678, 3, 1'b1);

    // Port 0 grant, then reset in WAIT: no ack, stray fl_valid ignored.
    @(negedge clk);
    bus.addr0 = 23'h000500;
    bus.req0  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.fl_read_op === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_issue_seen", {63'd0, found}, 64'd1);
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_ack0", {63'd0, bus.ack0}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.fl_valid = 1'b1;
    bus.fl_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.fl_valid = 1'b0;
    check("stray_busy", {63'd0, bus.busy}, 64'd0);
    repeat (2) @(negedge clk);
    check("stray_ack0", {63'd0, bus.ack0}, 64'd0);
    check("stray_ack1", {63'd0, bus.ack1}, 64'd0);
    check("stray_busy2", {63'd0, bus.busy}, 64'd0);

    // Pointer back to "port 1 last": port 0 wins contention.
    bus.addr0 = 23'h000600;
    bus.addr1 = 23'h000700;
    push_exp(1'b0, 32'h0BAD_CAFE, 1'b0);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    serve("post_rst", 23'h000600, 32'h0BAD_CAFE, 0, 1'b0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("final_busy", {63'd0, bus.busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
